nexus_nonce_collector: RTL and testbench
========================================

# nexus_nonce_collector

Collects good-nonce results from `CORES` Nexus hash transform cores in the `sysclk` domain and merges them into one buffered stream for the host interface. It sits directly downstream of each core's asynchronous nonce FIFO. That FIFO drains unconditionally (one-cycle `data_valid` pulses, no backpressure), so the collector must capture every pulse. It then arbitrates round-robin between cores and presents results on a valid/ready port. Lost results are counted and never silently discarded.

## Interface
Parameters:
- `CORES`, 4 — number of hash cores feeding the collector (1..16).
- `FIFO_DEPTH`, 8 — result FIFO entries; power of two, ≥2.
- `DROP_CNT_W`, 16 — width of the saturating drop counter.

Ports:
- `sysclk`  in  1 — single clock; all logic is in this domain.
- `rst`  in  1 — asynchronous, active-high reset.
- `core_nonce`  in  `CORES*64` — nonce from core i is on bits `[i*64 +: 64]`.
- `core_valid`  in  `CORES` — one-cycle strobe per result; no backpressure exists.
- `work_new`  in  1 — one-cycle pulse when a new work packet is issued; flushes stale results.
- `nonce_out`  out  64 — head-of-FIFO nonce.
- `nonce_core_idx`  out  `$clog2(CORES)` (minimum 1) — originating core of `nonce_out`.
- `nonce_valid`  out  1 — FIFO not empty.
- `nonce_ready`  in  1 — consumer accepts the head entry when `nonce_valid && nonce_ready`.
- `drop_count`  out  `DROP_CNT_W` — count of results lost to slot overflow; saturates.

## Operation
- **Per-core slot.** Each core has a 1-deep slot: a valid bit plus 64-bit nonce.
  - `core_valid[i]` loads slot i at the next edge.
- **Overflow.** If slot i is occupied, not granted this cycle, and `core_valid[i]` is high:
  - the new nonce is dropped;
  - the slot keeps its old value;
  - `drop_count` increments by the number of such cores this cycle, saturating at all-ones.
- **Grant and reload in the same cycle.** If slot i is granted in the same cycle as `core_valid[i]`, the slot reloads with the new nonce. No drop occurs.
- **Arbiter.**
  - Round-robin over occupied slots.
  - Search starts at the pointer `rr_ptr`.
  - At most one grant per cycle, and only when FIFO occupancy < `FIFO_DEPTH`. Full is determined from the registered count; a pop in the same cycle does not enable a push.
  - On a grant, `rr_ptr` becomes (granted index + 1) mod `CORES`.
- **FIFO.**
  - Each entry is {core_idx, nonce}, in show-ahead form.
  - Push occurs on grant; pop occurs on `nonce_valid && nonce_ready`.
  - Simultaneous push and pop while not full leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `nonce_out` and `nonce_core_idx` hold their value while `nonce_valid` is high and `nonce_ready` is low.
- **Flush (`work_new`).** At the next edge:
  - all slots are cleared;
  - the FIFO is emptied;
  - `rr_ptr` returns to 0;
  - any `core_valid` in the same cycle is discarded and not counted as a drop;
  - `drop_count` is unaffected.
  - A pop in the flush cycle is still a legal handshake. The entry is consumed, then the FIFO is empty.
- **`drop_count`** is cleared only by `rst`.

## Timing
- **Reset values:**
  - `nonce_out` = 0, `nonce_core_idx` = 0;
  - `nonce_valid` = 0, `drop_count` = 0;
  - all slots empty, `rr_ptr` = 0.
- **Reset mid-operation:** all state clears asynchronously.
- **Latency.** With the FIFO empty and no contention:
  - `core_valid` is high in cycle N;
  - the slot is occupied in N+1 and granted in N+1;
  - `nonce_valid` is high in N+2.
- **Contention latency.** Under full contention, a slot waits at most `CORES-1` extra cycles.
- **Throughput.** One result per cycle sustained into and out of the FIFO.
- **`nonce_valid`** is registered. It falls on the edge after the last entry is popped.

## Configuration
- **`NONCE_DEDUP_EN` defined:**
  - a last-pushed register, with its own valid bit, records the most recently pushed nonce;
  - a granted slot whose nonce equals it is cleared without pushing and without counting a drop;
  - the valid bit is cleared by `rst` and `work_new`.
  - This catches duplicate reports caused by overlapping core nonce ranges.
- **`NONCE_DEDUP_EN` undefined:** every grant pushes, and the dedup register is absent.

## Structure
- **Shared package `nexus_pkg`:**
  - `NONCE_W` = 64;
  - typedef `nonce_entry_t` {core_idx, nonce};
  - helper function for the core-index width, `$clog2` with a minimum of 1.
- **Sub-module `nexus_rr_arbiter`:**
  - parameterised by `CORES`;
  - inputs: request vector, enable;
  - outputs: one-hot grant, grant index;
  - owns `rr_ptr`.
- The FIFO is inline, with register storage; it is too shallow to justify BRAM.

## Test plan
- **Single result:** `core_valid[2]` pulse with nonce 0x0000_0001_DEAD_BEEF, ready high → `nonce_valid` in N+2 with that nonce and `nonce_core_idx`=2, one cycle only.
- **Simultaneous results:** all 4 cores pulse in the same cycle, nonces 0x10..0x13, `rr_ptr`=0 → outputs in order 0x10, 0x11, 0x12, 0x13 on consecutive cycles; `drop_count`=0.
- **Backpressure and overflow:**
  - with `nonce_ready`=0, send 8 results from core 0 and 1 every cycle → FIFO fills, slot 0 holds a result, `drop_count` counts each further valid;
  - release ready → 9 distinct results drain in order.
- **Flush:** with 3 entries queued, pulse `work_new` together with `core_valid[1]` → `nonce_valid`=0 on the next cycle, nothing from core 1 appears, `drop_count` unchanged.
- **Saturation:** with `DROP_CNT_W`=4, force 20 overflow events → `drop_count`=0xF.
- **Dedup:** 0xABCD from core 0, then 0xABCD from core 3 → one output with `NONCE_DEDUP_EN` defined, two outputs without it. After `work_new`, 0xABCD is accepted again.

Source files
------------

// File: rtl/nexus_pkg.sv
// Shared types and helpers for the Nexus nonce collector.
// Nonce width, FIFO entry layout and the core-index width function.
package nexus_pkg;

    localparam int NONCE_W   = 64;
    localparam int MAX_CORES = 16;
    // Entry storage always carries a full 4-bit core index; narrower builds
    // use the low bits only.
    localparam int MAX_IDX_W = 4;

    // Core-index width: $clog2 with a floor of 1 so a single core still has a port.
    function automatic int idx_width(input int cores);
        return (cores > 1) ? $clog2(cores) : 1;
    endfunction

    typedef struct packed {
        logic [MAX_IDX_W-1:0] core_idx;
        logic [NONCE_W-1:0]   nonce;
    } nonce_entry_t;

endpackage

// File: rtl/nexus_nonce_collector_if.sv
// Output stream of the nonce collector: show-ahead head entry with valid/ready.
// The collector drives the master side; the host consumer is the slave.
interface nexus_nonce_collector_if
    import nexus_pkg::*;
#(
    parameter int CORES = 4
);
    localparam int IDX_W = idx_width(CORES);

    logic [NONCE_W-1:0] nonce_out;
    logic [IDX_W-1:0]   nonce_core_idx;
    logic               nonce_valid;
    logic               nonce_ready;

    modport master (
        output nonce_out,
        output nonce_core_idx,
        output nonce_valid,
        input  nonce_ready
    );

    modport slave (
        input  nonce_out,
        input  nonce_core_idx,
        input  nonce_valid,
        output nonce_ready
    );

endinterface

// File: rtl/nexus_rr_arbiter.sv
// Round-robin arbiter over the per-core result slots.
// Single-cycle combinational grant; owns the rotating search pointer rr_ptr.
module nexus_rr_arbiter
    import nexus_pkg::*;
#(
    parameter  int CORES = 4,
    localparam int IDX_W = idx_width(CORES)
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [CORES-1:0] req_i,
    input  logic             en_i,
    output logic [CORES-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;

    // First requester at or after rr_ptr wins, wrapping modulo CORES.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front so no latch is inferred.
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < CORES; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= CORES) idx = idx - CORES;
            if (en_i && req_i[idx] && !found) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
            end
        end
    end

    // Pointer moves past the winner; flush restarts the search at core 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (found) begin
            rr_ptr_d = (int'(grant_idx_o) == CORES - 1) ? '0 : grant_idx_o + IDX_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge sysclk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/nexus_nonce_collector.sv
// Nexus nonce collector: captures one-cycle result strobes from CORES hash cores
// into 1-deep slots, arbitrates round-robin into a show-ahead result FIFO and
// counts results lost to slot overflow (saturating).
// Optional feature: define NONCE_DEDUP_EN to suppress a grant whose nonce equals
// the most recently pushed one.
module nexus_nonce_collector
    import nexus_pkg::*;
#(
    parameter int CORES      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                     sysclk,
    input  logic                     rst,
    input  logic [CORES*NONCE_W-1:0] core_nonce,
    input  logic [CORES-1:0]         core_valid,
    input  logic                     work_new,
    nexus_nonce_collector_if.master  out_if,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    localparam int IDX_W      = idx_width(CORES);
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = PTR_W + 1;
    localparam int DROP_SUM_W = DROP_CNT_W + 5;
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    logic [CORES-1:0]        slot_vld_q;
    logic [NONCE_W-1:0]      slot_nonce_q [CORES];
    logic [CORES-1:0]        grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any, fifo_room, push, pop, dup_hit;
    logic [NONCE_W-1:0]      grant_nonce;
    nonce_entry_t            push_entry;

    nonce_entry_t            fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    nonce_valid_q;

    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [DROP_SUM_W-1:0]   drop_inc, drop_sum;

    // Full is judged on the registered count; a same-cycle pop never frees room.
    assign fifo_room = (count_q < CNT_W'(FIFO_DEPTH));

    nexus_rr_arbiter #(.CORES(CORES)) u_arb (
        .sysclk      (sysclk),
        .rst         (rst),
        .flush_i     (work_new),
        .req_i       (slot_vld_q),
        .en_i        (fifo_room),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign grant_any   = |grant;
    assign grant_nonce = slot_nonce_q[grant_idx];
    assign push        = grant_any && !dup_hit;
    assign pop         = nonce_valid_q && out_if.nonce_ready;

    always_comb begin
        push_entry          = '0;
        push_entry.core_idx = MAX_IDX_W'(grant_idx);
        push_entry.nonce    = grant_nonce;
    end

`ifdef NONCE_DEDUP_EN
    logic               last_vld_q;
    logic [NONCE_W-1:0] last_nonce_q;

    assign dup_hit = last_vld_q && (grant_nonce == last_nonce_q);

    // Remember the most recently pushed nonce; a flush forgets it.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            last_vld_q   <= 1'b0;
            last_nonce_q <= '0;
        end else if (work_new) begin
            last_vld_q   <= 1'b0;
        end else if (push) begin
            last_vld_q   <= 1'b1;
            last_nonce_q <= grant_nonce;
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    // Slot capture: load when empty or being drained this cycle, else hold (overflow drops the new one).
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            slot_vld_q <= '0;
            for (int i = 0; i < CORES; i++) slot_nonce_q[i] <= '0;
        end else if (work_new) begin
            slot_vld_q <= '0;
        end else begin
            for (int i = 0; i < CORES; i++) begin
                if (core_valid[i] && (!slot_vld_q[i] || grant[i])) begin
                    slot_vld_q[i]   <= 1'b1;
                    slot_nonce_q[i] <= core_nonce[i*NONCE_W +: NONCE_W];
                end else if (grant[i]) begin
                    slot_vld_q[i]   <= 1'b0;
                end
            end
        end
    end

    // Count every core that strobes into an occupied, ungranted slot; saturate at all-ones.
    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < CORES; i++) begin
            drop_inc = drop_inc + DROP_SUM_W'(slot_vld_q[i] & ~grant[i] & core_valid[i]);
        end
        drop_sum   = DROP_SUM_W'(drop_cnt_q) + drop_inc;
        drop_cnt_d = (drop_sum > DROP_SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_CNT_W-1:0];
        if (work_new) drop_cnt_d = drop_cnt_q;
    end

    // Drop counter register; only reset clears it.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Result FIFO: push on grant, pop on handshake, flush empties it.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage array is reset because the head entry is visible on the outputs and must read zero after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            nonce_valid_q <= 1'b0;
        end else if (work_new) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            nonce_valid_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q       <= count_d;
            nonce_valid_q <= (count_d != '0);
        end
    end

    assign out_if.nonce_out      = fifo_mem_q[rd_ptr_q].nonce;
    assign out_if.nonce_core_idx = fifo_mem_q[rd_ptr_q].core_idx[IDX_W-1:0];
    assign out_if.nonce_valid    = nonce_valid_q;
    assign drop_count            = drop_cnt_q;

endmodule

// File: tb/tb_nexus_nonce_collector.sv
// Directed bench for nexus_nonce_collector (CORES=4, FIFO_DEPTH=8, DROP_CNT_W=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_nexus_nonce_collector;
    import nexus_pkg::*;

    localparam int CORES      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int DROP_CNT_W = 4;
`ifdef NONCE_DEDUP_EN
    localparam int DEDUP_EXP  = 1;
`else
    localparam int DEDUP_EXP  = 2;
`endif

    logic                     sysclk = 1'b0;
    logic                     rst;
    logic [CORES*NONCE_W-1:0] core_nonce;
    logic [CORES-1:0]         core_valid;
    logic                     work_new;
    logic [DROP_CNT_W-1:0]    drop_count;

    int n_cmp = 0;
    int n_mis = 0;
    int n_out;

    nexus_nonce_collector_if #(.CORES(CORES)) out_if ();

    nexus_nonce_collector #(
        .CORES      (CORES),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .core_nonce (core_nonce),
        .core_valid (core_valid),
        .work_new   (work_new),
        .out_if     (out_if),
        .drop_count (drop_count)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_nonce(input int i, input logic [63:0] v);
        core_nonce[i*NONCE_W +: NONCE_W] = v;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        core_valid = '0;
        work_new   = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst                = 1'b1;
        core_nonce         = '0;
        core_valid         = '0;
        work_new           = 1'b0;
        out_if.nonce_ready = 1'b0;
        #2;
        // Reset values
        check("rst_valid", out_if.nonce_valid, 0);
        check("rst_nonce", out_if.nonce_out, 0);
        check("rst_idx",   out_if.nonce_core_idx, 0);
        check("rst_drop",  drop_count, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single result from core 2: valid exactly in N+2, for one cycle
        out_if.nonce_ready = 1'b1;
        set_nonce(2, 64'h0000_0001_DEAD_BEEF);
        core_valid = 4'b0100;
        check("single_n0_valid", out_if.nonce_valid, 0);
        tick();
        core_valid = '0;
        check("single_n1_valid", out_if.nonce_valid, 0);
        tick();
        check("single_n2_valid", out_if.nonce_valid, 1);
        check("single_n2_nonce", out_if.nonce_out, 64'h0000_0001_DEAD_BEEF);
        check("single_n2_idx",   out_if.nonce_core_idx, 2);
        tick();
        check("single_n3_valid", out_if.nonce_valid, 0);

        // Simultaneous results from all cores, rr_ptr forced to 0 by a flush
        work_new = 1'b1;
        tick();
        work_new = 1'b0;
        for (int i = 0; i < CORES; i++) set_nonce(i, 64'h10 + 64'(i));
        core_valid = 4'b1111;
        tick();
        core_valid = '0;
        check("simul_n1_valid", out_if.nonce_valid, 0);
        tick();
        for (int k = 0; k < CORES; k++) begin
            check("simul_valid", out_if.nonce_valid, 1);
            check("simul_nonce", out_if.nonce_out, 64'h10 + 64'(k));
            check("simul_idx",   out_if.nonce_core_idx, 64'(k));
            tick();
        end
        check("simul_empty", out_if.nonce_valid, 0);
        check("simul_drop",  drop_count, 0);

        // Backpressure: core 0 strobes 12 cycles into a stalled FIFO
        do_reset();
        out_if.nonce_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            set_nonce(0, 64'h100 + 64'(c));
            core_valid = 4'b0001;
            tick();
        end
        core_valid = '0;
        check("bp_drop",  drop_count, 3);
        check("bp_valid", out_if.nonce_valid, 1);
        check("bp_head",  out_if.nonce_out, 64'h100);
        tick();
        check("bp_hold",  out_if.nonce_out, 64'h100);
        out_if.nonce_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("bp_drain_valid", out_if.nonce_valid, 1);
            check("bp_drain_nonce", out_if.nonce_out, 64'h100 + 64'(i));
            tick();
        end
        check("bp_drain_empty", out_if.nonce_valid, 0);
        check("bp_drop_kept",   drop_count, 3);

        // Flush with 3 queued entries; rr_ptr sits at 1 so core 1 leads
        out_if.nonce_ready = 1'b0;
        set_nonce(0, 64'h20);
        set_nonce(1, 64'h21);
        set_nonce(2, 64'h22);
        core_valid = 4'b0111;
        tick();
        core_valid = '0;
        tick();
        tick();
        tick();
        check("flush_pre_valid", out_if.nonce_valid, 1);
        check("flush_pre_head",  out_if.nonce_out, 64'h21);
        set_nonce(1, 64'h99);
        core_valid = 4'b0010;
        work_new   = 1'b1;
        tick();
        core_valid = '0;
        work_new   = 1'b0;
        check("flush_valid", out_if.nonce_valid, 0);
        check("flush_drop",  drop_count, 3);
        out_if.nonce_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_if.nonce_valid) n_out++;
            tick();
        end
        check("flush_no_output", n_out, 0);
        // rr_ptr must be back at 0: core 0 before core 3
        set_nonce(0, 64'h30);
        set_nonce(3, 64'h33);
        core_valid = 4'b1001;
        tick();
        core_valid = '0;
        tick();
        check("flush_rr_first",  out_if.nonce_out, 64'h30);
        check("flush_rr_idx0",   out_if.nonce_core_idx, 0);
        tick();
        check("flush_rr_second", out_if.nonce_out, 64'h33);
        check("flush_rr_idx3",   out_if.nonce_core_idx, 3);

        // Multi-core overflow and saturation: 5 cycles x 4 drops = 20 events
        do_reset();
        out_if.nonce_ready = 1'b0;
        for (int i = 0; i < CORES; i++) set_nonce(i, 64'h40 + 64'(i));
        for (int c = 0; c < 16; c++) begin
            if (c == 10) check("sat_drop_c10", drop_count, 0);
            if (c == 12) check("sat_drop_c12", drop_count, 8);
            if (c == 15) check("sat_drop_c15", drop_count, 4'hF);
            core_valid = (c == 0 || c == 4 || (c >= 9 && c <= 14)) ? 4'b1111 : 4'b0000;
            tick();
        end
        check("sat_full_valid", out_if.nonce_valid, 1);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        check("arst_valid", out_if.nonce_valid, 0);
        check("arst_drop",  drop_count, 0);
        check("arst_nonce", out_if.nonce_out, 0);
        tick();
        rst = 1'b0;
        tick();

        // Duplicate nonce from two cores
        out_if.nonce_ready = 1'b1;
        set_nonce(0, 64'hABCD);
        set_nonce(3, 64'hABCD);
        n_out = 0;
        for (int c = 0; c < 10; c++) begin
            core_valid = (c == 0) ? 4'b0001 : (c == 3) ? 4'b1000 : 4'b0000;
            if (out_if.nonce_valid) begin
                n_out++;
                check("dedup_nonce", out_if.nonce_out, 64'hABCD);
            end
            tick();
        end
        check("dedup_count", n_out, DEDUP_EXP);
        work_new = 1'b1;
        tick();
        work_new = 1'b0;
        n_out = 0;
        for (int c = 0; c < 6; c++) begin
            core_valid = (c == 0) ? 4'b1000 : 4'b0000;
            if (out_if.nonce_valid) begin
                n_out++;
                check("dedup_after_flush_idx", out_if.nonce_core_idx, 3);
            end
            tick();
        end
        check("dedup_after_flush_count", n_out, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
